fifo_rr_drain: RTL and testbench

//   Router output stage sitting directly downstream of NUM_IN input fifo instances.

---
 rtl/fifo_rr_drain.sv | 97 +++++++++
 tb/tb_fifo_rr_drain.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_rr_drain.sv
// Round-robin drain stage: pops one non-empty upstream fifo per cycle and
// presents the item on a registered valid/ready output link.
module fifo_rr_drain #(
  parameter int NUM_IN = 4,
  parameter int SIZE   = 2,
  parameter int CNT_W  = 16,
  localparam int SRC_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_IN-1:0]      empty,
  input  logic [NUM_IN*SIZE-1:0] item_in,
  output logic [NUM_IN-1:0]      read,
  output logic                   out_valid,
  output logic [SIZE-1:0]        out_item,
  input  logic                   out_ready,
  output logic [SRC_W-1:0]       out_src,
  output logic [CNT_W-1:0]       fwd_count
);

  typedef enum logic {EMPTY, FULL} state_t;

  localparam logic [SRC_W-1:0] LAST_INIT = SRC_W'(NUM_IN - 1);

  state_t            state, state_next;
  logic [SRC_W-1:0]  last_grant;
  logic [NUM_IN-1:0] req;
  logic              drain;
  logic              load_ok;
  logic              grant_found;
  logic [SRC_W-1:0]  grant_idx;
  logic              grant_valid;

  // base + k with base < NUM_IN and 1 <= k <= NUM_IN needs at most one wrap
  function automatic logic [SRC_W-1:0] wrap_idx(input logic [SRC_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_IN) s = s - NUM_IN;
    return SRC_W'(s);
  endfunction

  assign req     = ~empty;
  assign drain   = out_valid & out_ready;
  assign load_ok = !out_valid | out_ready;

  // Search starts just past the last winner so every requester is served in turn
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NUM_IN; k++) begin
      if (!grant_found && req[wrap_idx(last_grant, k)]) begin
        grant_found = 1'b1;
        grant_idx   = wrap_idx(last_grant, k);
      end
    end
  end

  assign grant_valid = load_ok & grant_found & !reset;

  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (grant_valid) state_next = FULL;
      FULL:  if (!grant_valid && drain) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    out_valid = (state == FULL);
    read      = '0;
    if (grant_valid) read[grant_idx] = 1'b1;
  end

  // A drain that coincides with a load is simply overwritten, giving no bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      out_item   <= '0;
      out_src    <= '0;
      last_grant <= LAST_INIT;
      fwd_count  <= '0;
    end else begin
      if (grant_valid) begin
        out_item   <= item_in[grant_idx*SIZE +: SIZE];
        out_src    <= grant_idx;
        last_grant <= grant_idx;
      end
      if (drain) fwd_count <= fwd_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rr_drain.sv
// Bench for fifo_rr_drain: behavioural upstream fifos plus an output scoreboard
// that is checked on every accepted item.
module tb_fifo_rr_drain;

  localparam int NUM_IN = 4;
  localparam int SIZE   = 2;
  localparam int CNT_W  = 8;

  typedef struct {
    logic [1:0] src;
    logic [1:0] item;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [NUM_IN-1:0]      empty;
  logic [NUM_IN*SIZE-1:0] item_in;
  logic [NUM_IN-1:0]      read;
  logic                   out_valid;
  logic [SIZE-1:0]        out_item;
  logic                   out_ready;
  logic [1:0]             out_src;
  logic [CNT_W-1:0]       fwd_count;

  logic [1:0] fq [NUM_IN][$];
  exp_t       exp_q [$];
  int         errors = 0;
  int         checks = 0;

  fifo_rr_drain #(.NUM_IN(NUM_IN), .SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .empty(empty), .item_in(item_in), .read(read),
    .out_valid(out_valid), .out_item(out_item), .out_ready(out_ready),
    .out_src(out_src), .fwd_count(fwd_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0d, want %0d", name, $time, actual, expected);
    end
  endtask

  task automatic push_expected(input logic [1:0] src, input logic [1:0] item);
    exp_t e;
    e.src  = src;
    e.item = item;
    exp_q.push_back(e);
  endtask

  // One clock cycle: drive fifo heads, check read before the edge, pop popped fifos
  task automatic applyStimulus(input logic rst, input logic rdy, input logic [3:0] exp_read);
    logic [NUM_IN-1:0] cap;
    reset     = rst;
    out_ready = rdy;
    for (int i = 0; i < NUM_IN; i++) begin
      empty[i] = (fq[i].size() == 0);
      item_in[i*SIZE +: SIZE] = empty[i] ? 2'b00 : fq[i][0];
    end
    #2;
    checkOutput("read", 16'(read), 16'(exp_read));
    cap = read;
    @(posedge clk);
    for (int i = 0; i < NUM_IN; i++)
      if (cap[i] && fq[i].size() != 0) void'(fq[i].pop_front());
    #1;
  endtask

  // Scoreboard monitor: every accepted item must match the next expected entry
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_item at %0t: got src %0d item %0d, want none", $time, out_src, out_item);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("sb_item", 16'(out_item), 16'(e.item));
        checkOutput("sb_src", 16'(out_src), 16'(e.src));
      end
    end
  end

  initial begin
    reset     = 1'b1;
    out_ready = 1'b0;
    empty     = '1;
    item_in   = '0;
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b1, 4'b0000);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("rst_valid", 16'(out_valid), 16'd0);
    checkOutput("rst_item", 16'(out_item), 16'd0);
    checkOutput("rst_src", 16'(out_src), 16'd0);
    checkOutput("rst_count", 16'(fwd_count), 16'd0);

    $display("[TB] T1 first grant after reset");
    fq[0].push_back(2'd3);
    push_expected(2'd0, 2'd3);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    checkOutput("t1_valid", 16'(out_valid), 16'd1);
    checkOutput("t1_item", 16'(out_item), 16'd3);
    checkOutput("t1_src", 16'(out_src), 16'd0);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("t1_drained", 16'(out_valid), 16'd0);
    checkOutput("t1_count", 16'(fwd_count), 16'd1);

    $display("[TB] T2 full rotation");
    applyStimulus(1'b1, 1'b0, 4'b0000);
    fq[0].push_back(2'd1); fq[0].push_back(2'd2);
    fq[1].push_back(2'd3); fq[1].push_back(2'd0);
    fq[2].push_back(2'd2); fq[2].push_back(2'd1);
    fq[3].push_back(2'd0); fq[3].push_back(2'd3);
    push_expected(2'd0, 2'd1); push_expected(2'd1, 2'd3);
    push_expected(2'd2, 2'd2); push_expected(2'd3, 2'd0);
    push_expected(2'd0, 2'd2); push_expected(2'd1, 2'd0);
    push_expected(2'd2, 2'd1); push_expected(2'd3, 2'd3);
    for (int c = 0; c < 8; c++) begin
      applyStimulus(1'b0, 1'b1, 4'(1 << (c % 4)));
      checkOutput("t2_no_bubble", 16'(out_valid), 16'd1);
    end
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("t2_count", 16'(fwd_count), 16'd8);
    checkOutput("t2_valid", 16'(out_valid), 16'd0);

    $display("[TB] T3 backpressure");
    fq[0].push_back(2'd2); fq[1].push_back(2'd1);
    fq[2].push_back(2'd3); fq[3].push_back(2'd0);
    push_expected(2'd0, 2'd2);
    applyStimulus(1'b0, 1'b0, 4'b0001);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, 1'b0, 4'b0000);
      checkOutput("t3_hold_item", 16'(out_item), 16'd2);
      checkOutput("t3_hold_src", 16'(out_src), 16'd0);
      checkOutput("t3_hold_valid", 16'(out_valid), 16'd1);
    end
    push_expected(2'd1, 2'd1); push_expected(2'd2, 2'd3); push_expected(2'd3, 2'd0);
    applyStimulus(1'b0, 1'b1, 4'b0010);
    checkOutput("t3_reload_src", 16'(out_src), 16'd1);
    checkOutput("t3_reload_item", 16'(out_item), 16'd1);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b1000);
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("t3_count", 16'(fwd_count), 16'd12);

    $display("[TB] T4 idle cycles keep priority");
    fq[2].push_back(2'd1);
    push_expected(2'd2, 2'd1);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0, 1'b1, 4'b0000);
    fq[0].push_back(2'd3); fq[3].push_back(2'd2);
    push_expected(2'd3, 2'd2); push_expected(2'd0, 2'd3);
    applyStimulus(1'b0, 1'b1, 4'b1000);
    checkOutput("t4_first_src", 16'(out_src), 16'd3);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    checkOutput("t4_second_src", 16'(out_src), 16'd0);
    applyStimulus(1'b0, 1'b1, 4'b0000);

    $display("[TB] T5 reset mid-operation");
    fq[1].push_back(2'd2); fq[2].push_back(2'd3);
    applyStimulus(1'b0, 1'b0, 4'b0010);
    checkOutput("t5_loaded", 16'(out_valid), 16'd1);
    applyStimulus(1'b1, 1'b1, 4'b0000);
    checkOutput("t5_valid", 16'(out_valid), 16'd0);
    checkOutput("t5_count", 16'(fwd_count), 16'd0);
    checkOutput("t5_item", 16'(out_item), 16'd0);
    checkOutput("t5_fifo2_kept", 16'(fq[2].size()), 16'd1);
    fq[0].push_back(2'd1);
    push_expected(2'd0, 2'd1); push_expected(2'd2, 2'd3);
    applyStimulus(1'b0, 1'b1, 4'b0001);
    checkOutput("t5_first_src", 16'(out_src), 16'd0);
    applyStimulus(1'b0, 1'b1, 4'b0100);
    applyStimulus(1'b0, 1'b1, 4'b0000);

    $display("[TB] T6 counter wrap");
    applyStimulus(1'b1, 1'b0, 4'b0000);
    for (int i = 0; i < 64; i++)
      for (int k = 0; k < NUM_IN; k++) fq[k].push_back(2'((i + k) & 3));
    fq[0].push_back(2'd0);
    for (int j = 0; j < 257; j++) push_expected(2'(j % 4), 2'(((j / 4) + (j % 4)) & 3));
    for (int j = 0; j < 257; j++) applyStimulus(1'b0, 1'b1, 4'(1 << (j % 4)));
    applyStimulus(1'b0, 1'b1, 4'b0000);
    checkOutput("t6_count_wrap", 16'(fwd_count), 16'd1);
    checkOutput("sb_drained", 16'(exp_q.size()), 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
